// File: rtl/pipe_reg_pkg.sv
// pipe_reg_pkg: shared constants and helpers for the pipe_reg block.
//   DEF_BITS   - default data width
//   DEF_STAGES - default pipeline depth
//   occ_w()    - width of the occupancy counter for a given depth
package pipe_reg_pkg;

  localparam int DEF_BITS   = 8;
  localparam int DEF_STAGES = 3;

  // Counter must represent 0..stages inclusive.
  function automatic int occ_w(input int stages);
    return (stages < 1) ? 1 : $clog2(stages + 1);
  endfunction

endpackage

// File: rtl/pipe_reg_stage.sv
// pipe_stage: one register stage of the pipe_reg elastic pipeline.
// Ports:
//   i_clk       - clock, rising edge
//   i_rst_n     - synchronous active-low reset
//   i_clr       - synchronous clear (flush or clear-on-disable)
//   i_en        - global enable; stage holds when low
//   i_up_valid  - valid offered by the upstream side
//   i_up_data   - data offered by the upstream side
//   i_dn_ready  - downstream side can take this stage's word
//   o_valid     - stage holds a word
//   o_data      - stage data (zero when empty)
module pipe_stage
  import pipe_reg_pkg::*;
#(
  parameter int BITS = DEF_BITS
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_clr,
  input  logic            i_en,
  input  logic            i_up_valid,
  input  logic [BITS-1:0] i_up_data,
  input  logic            i_dn_ready,
  output logic            o_valid,
  output logic [BITS-1:0] o_data
);

  logic            r_valid;
  logic [BITS-1:0] r_data;
  logic            w_ready;

  // Empty stages always accept, so bubbles collapse toward the output.
  assign w_ready = !r_valid || i_dn_ready;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n || i_clr) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (i_en && w_ready) begin
      // A ready stage either receives the upstream word or becomes a bubble.
      r_valid <= i_up_valid;
      r_data  <= i_up_valid ? i_up_data : '0;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;

endmodule

// File: rtl/pipe_reg.sv
// pipe_reg: elastic valid/ready register pipeline of STAGES stages.
// Optional feature: define PIPE_REG_FLUSH_EN to add the FLUSH input, which
// empties the pipe on the edge and blocks input while asserted.
// Ports:
//   CLK       - clock, rising edge
//   RESET_N   - synchronous active-low reset
//   EN        - global enable (hold or clear when low, see CLR_ON_DIS)
//   IN_VALID  - upstream word valid
//   IN_READY  - pipe accepts D this cycle
//   D         - input data
//   OUT_VALID - Q carries a valid word
//   OUT_READY - downstream accepts Q
//   Q         - output data, zero when OUT_VALID is low
//   OCC       - number of occupied stages
//   FLUSH     - (PIPE_REG_FLUSH_EN only) empty the pipe
module pipe_reg
  import pipe_reg_pkg::*;
#(
  parameter int BITS       = DEF_BITS,
  parameter int STAGES     = DEF_STAGES,
  parameter bit CLR_ON_DIS = 1'b0
) (
  input  logic                       CLK,
  input  logic                       RESET_N,
  input  logic                       EN,
  input  logic                       IN_VALID,
  output logic                       IN_READY,
  input  logic [BITS-1:0]            D,
  output logic                       OUT_VALID,
  input  logic                       OUT_READY,
  output logic [BITS-1:0]            Q,
  output logic [occ_w(STAGES)-1:0]   OCC
`ifdef PIPE_REG_FLUSH_EN
  ,
  input  logic                       FLUSH
`endif
);

  localparam int OCC_W = occ_w(STAGES);

  logic [STAGES-1:0] w_valid;
  logic [BITS-1:0]   w_data [STAGES];
  logic              w_flush;
  logic              w_clr;
  logic              w_rdy0;
  logic              w_in_xfer;
  logic              w_out_xfer;
  logic [OCC_W-1:0]  r_occ;

`ifdef PIPE_REG_FLUSH_EN
  assign w_flush = FLUSH;
`else
  assign w_flush = 1'b0;
`endif

  assign w_clr = w_flush || (CLR_ON_DIS && !EN);

  // Stage 0 is ready when any stage is empty or the tail is draining; this
  // is the unrolled form of the per-stage chain and avoids a feedback net.
  assign w_rdy0     = OUT_READY || !(&w_valid);
  assign IN_READY   = EN && RESET_N && !w_flush && w_rdy0;
  assign OUT_VALID  = EN && RESET_N && w_valid[STAGES-1];
  assign Q          = OUT_VALID ? w_data[STAGES-1] : '0;
  assign w_in_xfer  = IN_VALID && IN_READY;
  assign w_out_xfer = OUT_VALID && OUT_READY;
  assign OCC        = r_occ;

  for (genvar i = 0; i < STAGES; i++) begin : g_stage
    logic            w_up_valid;
    logic [BITS-1:0] w_up_data;
    logic            w_dn_ready;

    if (i == 0) begin : g_first
      assign w_up_valid = w_in_xfer;
      assign w_up_data  = D;
    end else begin : g_mid
      assign w_up_valid = w_valid[i-1];
      assign w_up_data  = w_data[i-1];
    end

    // Downstream of stage i is ready when some later stage is empty or the
    // tail drains this cycle.
    if (i == STAGES - 1) begin : g_last
      assign w_dn_ready = OUT_READY;
    end else begin : g_inner
      assign w_dn_ready = OUT_READY || !(&w_valid[STAGES-1:i+1]);
    end

    pipe_stage #(
      .BITS(BITS)
    ) u_stage (
      .i_clk      (CLK),
      .i_rst_n    (RESET_N),
      .i_clr      (w_clr),
      .i_en       (EN),
      .i_up_valid (w_up_valid),
      .i_up_data  (w_up_data),
      .i_dn_ready (w_dn_ready),
      .o_valid    (w_valid[i]),
      .o_data     (w_data[i])
    );
  end

  always_ff @(posedge CLK) begin
    if (!RESET_N || w_clr) begin
      r_occ <= '0;
    end else if (EN) begin
      if (w_in_xfer && !w_out_xfer) begin
        r_occ <= r_occ + OCC_W'(1);
      end else if (w_out_xfer && !w_in_xfer) begin
        r_occ <= r_occ - OCC_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_pipe_reg.sv
// tb_pipe_reg: directed and randomized bench for pipe_reg (BITS=8, STAGES=3).
// Two instances share all inputs: u0 holds on EN low, u1 clears on EN low.
module tb_pipe_reg;

  localparam int S = 3;

  typedef struct {
    logic [7:0] d;
    int         p;
  } ent_t;

  logic       clk = 1'b0;
  logic       RESET_N, EN, IN_VALID, OUT_READY, FLUSH;
  logic [7:0] D;
  logic       in_rdy  [2];
  logic       out_vld [2];
  logic [7:0] q       [2];
  logic [1:0] occ     [2];

  ent_t       mq [2][$];
  logic [7:0] got[$];
  int         n_cmp = 0;
  int         n_bad = 0;
  int         n_in0 = 0;
  const bit   clr_dis [2] = '{1'b0, 1'b1};

  always #5 clk = ~clk;

  pipe_reg #(.BITS(8), .STAGES(S), .CLR_ON_DIS(1'b0)) u0 (
    .CLK(clk), .RESET_N(RESET_N), .EN(EN), .IN_VALID(IN_VALID),
    .IN_READY(in_rdy[0]), .D(D), .OUT_VALID(out_vld[0]),
    .OUT_READY(OUT_READY), .Q(q[0]), .OCC(occ[0])
`ifdef PIPE_REG_FLUSH_EN
    , .FLUSH(FLUSH)
`endif
  );

  pipe_reg #(.BITS(8), .STAGES(S), .CLR_ON_DIS(1'b1)) u1 (
    .CLK(clk), .RESET_N(RESET_N), .EN(EN), .IN_VALID(IN_VALID),
    .IN_READY(in_rdy[1]), .D(D), .OUT_VALID(out_vld[1]),
    .OUT_READY(OUT_READY), .Q(q[1]), .OCC(occ[1])
`ifdef PIPE_REG_FLUSH_EN
    , .FLUSH(FLUSH)
`endif
  );

  // Reference model: a queue of words, each with the stage position it
  // currently occupies. Words move forward one position per enabled edge
  // unless blocked by the word ahead of them.
  function automatic logic m_in_ready(int m);
    return EN && RESET_N && !FLUSH && ((mq[m].size() < S) || OUT_READY);
  endfunction

  function automatic logic m_out_valid(int m);
    return EN && RESET_N && (mq[m].size() > 0) && (mq[m][0].p == S - 1);
  endfunction

  function automatic logic [7:0] m_q(int m);
    return m_out_valid(m) ? mq[m][0].d : 8'h00;
  endfunction

  task automatic m_step(int m);
    logic inx, outx;
    int   lim;
    ent_t e;
    if (!RESET_N || FLUSH) begin
      mq[m].delete();
      return;
    end
    if (!EN) begin
      if (clr_dis[m]) mq[m].delete();
      return;
    end
    inx  = IN_VALID && m_in_ready(m);
    outx = m_out_valid(m) && OUT_READY;
    if (outx) void'(mq[m].pop_front());
    lim = S;
    for (int k = 0; k < mq[m].size(); k++) begin
      mq[m][k].p = (mq[m][k].p + 1 < lim - 1) ? mq[m][k].p + 1 : lim - 1;
      lim = mq[m][k].p;
    end
    if (inx) begin
      e.d = D;
      e.p = 0;
      mq[m].push_back(e);
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    for (int m = 0; m < 2; m++) begin
      chk($sformatf("u%0d_in_ready", m),  32'(in_rdy[m]),  32'(m_in_ready(m)));
      chk($sformatf("u%0d_out_valid", m), 32'(out_vld[m]), 32'(m_out_valid(m)));
      chk($sformatf("u%0d_q", m),         32'(q[m]),       32'(m_q(m)));
      chk($sformatf("u%0d_occ", m),       32'(occ[m]),     32'(mq[m].size()));
    end
  endtask

  // Check at the falling edge, advance the model, then let the rising edge
  // happen; returns 1 time unit after the edge.
  task automatic cycle();
    @(negedge clk);
    check_all();
    if (out_vld[0] === 1'b1 && OUT_READY) got.push_back(q[0]);
    if (in_rdy[0] === 1'b1 && IN_VALID)   n_in0++;
    m_step(0);
    m_step(1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int   idx;
    logic acc;

    RESET_N = 1'b0; EN = 1'b1; IN_VALID = 1'b0; OUT_READY = 1'b0;
    FLUSH = 1'b0; D = 8'h00;
    @(posedge clk); #1;
    cycle();
    chk("reset_occ", 32'(occ[0]), 0);
    chk("reset_in_ready", 32'(in_rdy[0]), 0);
    chk("reset_out_valid", 32'(out_vld[0]), 0);

    // Single word through an empty pipe.
    RESET_N = 1'b1; OUT_READY = 1'b1; IN_VALID = 1'b1; D = 8'hA5;
    cycle();
    IN_VALID = 1'b0;
    cycle();
    chk("a5_early_valid", 32'(out_vld[0]), 0);
    cycle();
    chk("a5_valid", 32'(out_vld[0]), 1);
    chk("a5_q", 32'(q[0]), 32'h A5);
    cycle();
    chk("a5_occ_after", 32'(occ[0]), 0);

    // Fill with OUT_READY low, then drain in order.
    got.delete();
    OUT_READY = 1'b0; IN_VALID = 1'b1; idx = 0;
    for (int t = 0; t < 10 && idx < 3; t++) begin
      D = 8'(idx + 1);
      acc = m_in_ready(0);
      cycle();
      if (acc) idx++;
    end
    D = 8'(idx + 1);
    #1;
    chk("full_in_ready", 32'(in_rdy[0]), 0);
    chk("full_occ", 32'(occ[0]), 3);
    for (int t = 0; t < 30 && got.size() < 6; t++) begin
      IN_VALID = (idx < 6);
      D = 8'(idx + 1);
      OUT_READY = 1'b1;
      acc = IN_VALID && m_in_ready(0);
      cycle();
      if (acc) idx++;
    end
    chk("stream_count", got.size(), 6);
    for (int k = 0; k < 6 && k < got.size(); k++)
      chk($sformatf("stream_word%0d", k), 32'(got[k]), 32'(k + 1));

    // Full pipe with simultaneous in/out transfers.
    IN_VALID = 1'b1; OUT_READY = 1'b0; idx = 0;
    for (int t = 0; t < 10 && idx < 3; t++) begin
      D = 8'(8'h10 + idx);
      acc = m_in_ready(0);
      cycle();
      if (acc) idx++;
    end
    got.delete(); n_in0 = 0; OUT_READY = 1'b1;
    for (int k = 0; k < 4; k++) begin
      D = 8'(8'h20 + k);
      cycle();
      chk($sformatf("thru_occ%0d", k), 32'(occ[0]), 3);
    end
    chk("thru_in_count", n_in0, 4);
    chk("thru_out_count", got.size(), 4);
    if (got.size() > 0) chk("thru_first_word", 32'(got[0]), 32'h10);
    IN_VALID = 1'b0;
    for (int k = 0; k < 5; k++) cycle();

    // Enable dropped for 5 cycles with two words in flight.
    OUT_READY = 1'b0; IN_VALID = 1'b1;
    D = 8'h41; cycle();
    D = 8'h42; cycle();
    IN_VALID = 1'b1; D = 8'h99; OUT_READY = 1'b1; EN = 1'b0;
    for (int k = 0; k < 5; k++) cycle();
    chk("dis_hold_occ", 32'(occ[0]), 2);
    chk("dis_hold_valid", 32'(out_vld[0]), 0);
    chk("dis_clr_occ", 32'(occ[1]), 0);
    chk("dis_clr_valid", 32'(out_vld[1]), 0);
    EN = 1'b1; IN_VALID = 1'b0; got.delete();
    for (int k = 0; k < 6; k++) cycle();
    chk("resume_count", got.size(), 2);
    if (got.size() == 2) begin
      chk("resume_w0", 32'(got[0]), 32'h41);
      chk("resume_w1", 32'(got[1]), 32'h42);
    end

    // Reset mid-stream with two words held.
    OUT_READY = 1'b0; IN_VALID = 1'b1;
    D = 8'h51; cycle();
    D = 8'h52; cycle();
    chk("pre_rst_occ", 32'(occ[0]), 2);
    RESET_N = 1'b0; IN_VALID = 1'b0;
    cycle();
    chk("rst_occ", 32'(occ[0]), 0);
    chk("rst_q", 32'(q[0]), 0);
    chk("rst_valid", 32'(out_vld[0]), 0);
    RESET_N = 1'b1; OUT_READY = 1'b1; IN_VALID = 1'b1; D = 8'h3C;
    cycle();
    IN_VALID = 1'b0; got.delete();
    for (int k = 0; k < 5; k++) cycle();
    chk("post_rst_count", got.size(), 1);
    if (got.size() == 1) chk("post_rst_word", 32'(got[0]), 32'h3C);

`ifdef PIPE_REG_FLUSH_EN
    // Flush a full pipe while a word is offered.
    OUT_READY = 1'b0; IN_VALID = 1'b1;
    for (int k = 0; k < 3; k++) begin
      D = 8'(8'h61 + k);
      cycle();
    end
    FLUSH = 1'b1; D = 8'h77;
    #1;
    chk("flush_in_ready", 32'(in_rdy[0]), 0);
    cycle();
    chk("flush_occ", 32'(occ[0]), 0);
    FLUSH = 1'b0; IN_VALID = 1'b0; OUT_READY = 1'b1; got.delete();
    for (int k = 0; k < 5; k++) cycle();
    chk("flush_nothing_out", got.size(), 0);
`endif

    // Randomized traffic checked cycle by cycle against the model.
    for (int t = 0; t < 400; t++) begin
      EN        = ($urandom_range(0, 9) != 0);
      RESET_N   = ($urandom_range(0, 49) != 0);
      IN_VALID  = 1'($urandom_range(0, 1));
      OUT_READY = ($urandom_range(0, 3) != 0);
      D         = 8'($urandom);
`ifdef PIPE_REG_FLUSH_EN
      FLUSH     = ($urandom_range(0, 39) == 0);
`endif
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
